// File: rtl/hybrid_noc_router_output_arb.sv
// ---------------------------------------------------------------------------
// hybrid_noc_router_output_arb
//
// Output-port arbiter of a NoC router. PORTS input lookup stages compete for
// one output link. Arbitration is round-robin at packet granularity. A
// winner's packet holds the output until its last flit has transferred, so
// flits of different packets never interleave. The output is a single
// registered stage. It accepts a new flit whenever it is empty or being
// drained in the same cycle.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-high reset
//   in_flit    : PORTS packed flits, input i in [i*FLIT_WIDTH +: FLIT_WIDTH]
//   in_valid   : per-input request for this output
//   in_last    : per-input last-flit-of-packet marker
//   in_ready   : per-input accept (combinational from in_valid/out_ready)
//   out_flit   : registered output flit
//   out_valid  : out_flit holds a valid flit
//   out_last   : registered last marker
//   out_ready  : downstream accepts out_flit
// ---------------------------------------------------------------------------
module hybrid_noc_router_output_arb #(
  parameter int FLIT_WIDTH = 32,
  parameter int PORTS      = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*FLIT_WIDTH-1:0] in_flit,
  input  logic [PORTS-1:0]            in_valid,
  input  logic [PORTS-1:0]            in_last,
  output logic [PORTS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]       out_flit,
  output logic                        out_valid,
  output logic                        out_last,
  input  logic                        out_ready
);

  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       gnt_q, gnt_d;
  logic [IDX_W-1:0]       prio_q, prio_d;
  logic [FLIT_WIDTH-1:0]  out_flit_q, out_flit_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;

  logic                   can_update;
  logic                   found;
  logic [IDX_W-1:0]       sel;
  logic [IDX_W-1:0]       cand;
  int                     scan_idx;
  logic [PORTS-1:0]       ready_c;
  logic [IDX_W-1:0]       winner;
  logic                   xfer;
  logic                   win_last;
  logic [FLIT_WIDTH-1:0]  win_flit;

  // Round-robin successor, wrapping PORTS-1 back to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] v);
    if (v == IDX_W'(PORTS - 1)) return '0;
    else                        return v + 1'b1;
  endfunction

  // Arbitration and handshake
  always_comb begin
    can_update = ~out_valid_q | out_ready;

    // The first requester at or after prio, wrapping mod PORTS.
    found    = 1'b0;
    sel      = '0;
    cand     = '0;
    scan_idx = 0;
    for (int k = 0; k < PORTS; k++) begin
      scan_idx = int'(prio_q) + k;
      if (scan_idx >= PORTS) scan_idx = scan_idx - PORTS;
      cand = IDX_W'(scan_idx);
      if (!found && in_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    // A locked owner gets ready even during a gap. Everyone else is blocked.
    ready_c = '0;
    if (!rst && can_update) begin
      if (state_q == IDLE) begin
        if (found) ready_c[sel] = 1'b1;
      end else begin
        ready_c[gnt_q] = 1'b1;
      end
    end

    winner   = (state_q == IDLE) ? sel : gnt_q;
    xfer     = |(in_valid & ready_c);
    win_last = in_last[winner];
    win_flit = in_flit[int'(winner)*FLIT_WIDTH +: FLIT_WIDTH];
  end

  // Next state
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    prio_d      = prio_q;
    out_flit_d  = out_flit_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (xfer) begin
      out_flit_d  = win_flit;
      out_last_d  = win_last;
      out_valid_d = 1'b1;
      if (win_last) begin
        // Packet done: release the lock and rotate priority past the winner.
        state_d = IDLE;
        prio_d  = next_idx(winner);
      end else begin
        state_d = LOCKED;
        gnt_d   = winner;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      prio_q      <= '0;
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      prio_q      <= prio_d;
      out_flit_q  <= out_flit_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = ready_c;
  assign out_flit  = out_flit_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: doc/hybrid_noc_router_output_arb.md
HYBRID_NOC_ROUTER_OUTPUT_ARB -- requirements
Module: hybrid_noc_router_output_arb

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 32, flit width in bits.
REQ-002 SHALL have parameter PORTS, default 5, number of requesting input ports; this equals the router port count.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port in_flit, input, PORTS*FLIT_WIDTH, flit of input i in bits [i*FLIT_WIDTH +: FLIT_WIDTH].
REQ-006 SHALL have port in_valid, input, PORTS, bit i is input i's lookup stage requesting this output.
REQ-007 SHALL have port in_last, input, PORTS, bit i marks the last flit of input i's packet.
REQ-008 SHALL have port in_ready, output, PORTS, bit i accepts input i's flit.
REQ-009 SHALL have port out_flit, output, FLIT_WIDTH, registered output flit.
REQ-010 SHALL have port out_valid, output, 1, out_flit holds a valid flit.
REQ-011 SHALL have port out_last, output, 1, registered last marker.
REQ-012 SHALL have port out_ready, input, 1, the downstream link or buffer accepts out_flit.

Function
REQ-013 SHALL use a 1-entry output register; can_update = ~out_valid | out_ready.
REQ-014 SHALL transfer input i's flit when in_valid[i] & in_ready[i], latch flit/last into the output register and assert out_valid on the next cycle (latency 1).
REQ-015 SHALL clear out_valid after out_valid & out_ready when no new transfer occurs in the same cycle.
REQ-016 SHALL implement states IDLE and LOCKED with a grant index gnt and a round-robin pointer prio.
REQ-017 In IDLE with any in_valid set and can_update high, SHALL select the first set in_valid bit scanning prio, prio+1, ..., wrapping mod PORTS.
REQ-018 In IDLE, SHALL assert in_ready only for the selected input, so the head flit transfers in the same cycle.
REQ-019 On an IDLE transfer with in_last=0, SHALL go to LOCKED with gnt=selected.
REQ-020 On an IDLE transfer with in_last=1 (single-flit packet), SHALL stay in IDLE.
REQ-021 In LOCKED, SHALL set in_ready[gnt] = can_update and hold all other in_ready bits at 0.
REQ-022 In LOCKED, SHALL hold the lock while in_valid[gnt] is low (packet gap); other requesters stay blocked.
REQ-023 In LOCKED, on transfer of a flit with in_last[gnt]=1, SHALL return to IDLE.
REQ-024 On every packet-ending transfer SHALL set prio = (winner+1) mod PORTS, including wrap from PORTS-1 to 0.
REQ-025 SHALL arbitrate in IDLE the cycle after a LOCKED last transfer, giving back-to-back packets with no bubble.
REQ-026 With can_update low, SHALL hold in_ready all 0 and change neither state nor prio.
REQ-027 SHALL sustain one flit per cycle while out_ready stays high.
REQ-028 SHALL have no combinational path from out_ready to out_valid/out_flit; in_ready MAY depend combinationally on in_valid and out_ready.
REQ-029 SHALL never drop, duplicate or interleave flits of different packets on the output.

Reset
REQ-030 While rst is high, SHALL force state=IDLE, prio=0, gnt=0, out_valid=0, out_last=0, out_flit=0 and in_ready=0.
REQ-031 SHALL abandon any locked packet on mid-packet reset; upstream recovery is handled outside this block.

Verification
REQ-032 Single-flit contention: in_valid=5'b10110 with all last=1, out_ready=1 -> grants in order 1,2,4, one per cycle; out_valid high 3 cycles starting 1 cycle after first request.
REQ-033 Packet lock: input 3 sends a 4-flit packet A0..A3 while input 0 requests continuously -> out shows A0..A3 contiguously, then input 0's flit; prio=4 after A3.
REQ-034 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_flit stable, in_ready=0, prio unchanged; transfer resumes the cycle out_ready=1.
REQ-035 Gap in lock: input 2 locked with in_valid[2] low 2 cycles while input 1 requests -> in_ready[1] stays 0 until input 2's last flit transfers.
REQ-036 Wrap and reset: prio=4 with requests on 0 and 4 -> 4 wins, then 0; assert rst mid-packet -> out_valid=0, IDLE, next grant from prio=0.
